halfstrip_checker: RTL and testbench

- Downstream consumer of the eight triad decoders: takes the 32-bit decoded half-strip hit register, plus compout, after each injected pulse.
- Per trial, it opens a timed acceptance window, accumulates hits, compares them against the expected pattern, and maintains saturating error, trial, timeout and triad-skip counters.
- The trigger is the same fire_pulse that starts the injector.
- Results and counters are read by the serial block.

---
 rtl/comptest_pkg.sv | 20 ++
 rtl/sat_counter.sv | 29 ++
 rtl/halfstrip_checker.sv | 233 +++++++++++++++++++++++
 tb/tb_halfstrip_checker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comptest_pkg.sv
// Shared definitions for the half-strip comparator test path.
package comptest_pkg;

    localparam int HS_W          = 32;
    localparam int CNT_W_DEFAULT = 32;

    // Trial sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_COMPARE = 2'd3
    } state_t;

    // True when any half-strip bit is set.
    function automatic logic any_hit(input logic [HS_W-1:0] v);
        return (v != {HS_W{1'b0}});
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count up on inc, hold at all-ones, clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/halfstrip_checker.sv
// Per-trial checker of decoded half-strip hits and comparator output.
// Each arm opens a timed window, accumulates hits for a short settle
// period after the first one, compares against the snapshotted
// expectation and updates saturating statistics counters.
module halfstrip_checker
    import comptest_pkg::*;
#(
    parameter int TIMEOUT = 63,
    parameter int SETTLE  = 3,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clock40,
    input  logic             reset,
    input  logic             arm,
    input  logic [HS_W-1:0]  halfstrips,
    input  logic [HS_W-1:0]  halfstrips_expect,
    input  logic             compout,
    input  logic             compout_expect,
    input  logic             triad_skip,
    input  logic             halfstrips_errcnt_rst,
    input  logic             compout_errcnt_rst,
    output logic             ready,
    output logic             done,
    output logic [HS_W-1:0]  halfstrips_captured,
    output logic [7:0]       latency,
    output logic             timed_out,
    output logic [CNT_W-1:0] halfstrips_errcnt,
    output logic [CNT_W-1:0] compout_errcnt,
    output logic [CNT_W-1:0] trial_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];
    localparam logic [3:0] SETTLE_C  = SETTLE[3:0];

    state_t          state_r;
    state_t          state_s;
    logic [7:0]      timer_r;
    logic [3:0]      settle_ctr_r;
    logic [HS_W-1:0] hs_acc_r;
    logic [HS_W-1:0] hs_exp_r;
    logic            cmp_exp_r;
    logic            cmp_seen_r;
    logic            skip_seen_r;
    logic            to_flag_r;
    logic [7:0]      lat_r;

    logic            ready_r;
    logic            done_r;
    logic [HS_W-1:0] captured_r;
    logic [7:0]      latency_r;
    logic            timed_out_r;

    logic            hit_s;
    logic            timer_end_s;
    logic            trial_inc_s;
    logic            hs_err_inc_s;
    logic            cmp_err_inc_s;
    logic            to_inc_s;
    logic            skip_inc_s;

    assign hit_s       = any_hit(halfstrips);
    assign timer_end_s = (timer_r == TIMEOUT_C);

    // Trial state register; reset aborts any trial in progress.
    always_ff @(posedge clock40) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection; a hit takes precedence over the timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (hit_s) begin
                    if (SETTLE_C == 4'd0) begin
                        state_s = ST_COMPARE;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end else if (timer_end_s) begin
                    state_s = ST_COMPARE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (settle_ctr_r <= 4'd1) begin
                    state_s = ST_COMPARE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_COMPARE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Trial datapath: snapshots on arm, hit accumulation, timer and flags.
    always_ff @(posedge clock40) begin
        if (reset) begin
            timer_r      <= 8'd0;
            settle_ctr_r <= 4'd0;
            hs_acc_r     <= {HS_W{1'b0}};
            hs_exp_r     <= {HS_W{1'b0}};
            cmp_exp_r    <= 1'b0;
            cmp_seen_r   <= 1'b0;
            skip_seen_r  <= 1'b0;
            to_flag_r    <= 1'b0;
            lat_r        <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        timer_r     <= 8'd0;
                        hs_exp_r    <= halfstrips_expect;
                        cmp_exp_r   <= compout_expect;
                        hs_acc_r    <= {HS_W{1'b0}};
                        cmp_seen_r  <= 1'b0;
                        skip_seen_r <= 1'b0;
                        to_flag_r   <= 1'b0;
                        lat_r       <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    cmp_seen_r  <= cmp_seen_r | compout;
                    skip_seen_r <= skip_seen_r | triad_skip;
                    if (hit_s) begin
                        hs_acc_r     <= halfstrips;
                        lat_r        <= timer_r;
                        settle_ctr_r <= SETTLE_C;
                    end else if (timer_end_s) begin
                        to_flag_r <= 1'b1;
                        lat_r     <= TIMEOUT_C;
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    hs_acc_r     <= hs_acc_r | halfstrips;
                    cmp_seen_r   <= cmp_seen_r | compout;
                    skip_seen_r  <= skip_seen_r | triad_skip;
                    settle_ctr_r <= settle_ctr_r - 4'd1;
                end
                default: begin
                    timer_r <= timer_r;
                end
            endcase
        end
    end

    // Counter increment requests, only during the single compare cycle.
    always_comb begin
        trial_inc_s   = 1'b0;
        hs_err_inc_s  = 1'b0;
        cmp_err_inc_s = 1'b0;
        to_inc_s      = 1'b0;
        skip_inc_s    = 1'b0;
        if (state_r == ST_COMPARE) begin
            trial_inc_s   = 1'b1;
            hs_err_inc_s  = (hs_acc_r != hs_exp_r);
            cmp_err_inc_s = (cmp_seen_r != cmp_exp_r);
            to_inc_s      = to_flag_r;
            skip_inc_s    = skip_seen_r;
        end else begin
            trial_inc_s   = 1'b0;
        end
    end

    // Registered result outputs, published when a trial completes.
    always_ff @(posedge clock40) begin
        if (reset) begin
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            captured_r  <= {HS_W{1'b0}};
            latency_r   <= 8'd0;
            timed_out_r <= 1'b0;
        end else begin
            ready_r <= (state_s == ST_IDLE);
            done_r  <= (state_r == ST_COMPARE);
            if (state_r == ST_COMPARE) begin
                captured_r  <= hs_acc_r;
                latency_r   <= lat_r;
                timed_out_r <= to_flag_r;
            end
        end
    end

    assign ready               = ready_r;
    assign done                = done_r;
    assign halfstrips_captured = captured_r;
    assign latency             = latency_r;
    assign timed_out           = timed_out_r;

    sat_counter #(.W(CNT_W)) u_trial_cnt (
        .clk(clock40), .rst(reset), .inc(trial_inc_s), .clr(1'b0), .count(trial_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hs_errcnt (
        .clk(clock40), .rst(reset), .inc(hs_err_inc_s), .clr(halfstrips_errcnt_rst),
        .count(halfstrips_errcnt)
    );

    sat_counter #(.W(CNT_W)) u_cmp_errcnt (
        .clk(clock40), .rst(reset), .inc(cmp_err_inc_s), .clr(compout_errcnt_rst),
        .count(compout_errcnt)
    );

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk(clock40), .rst(reset), .inc(to_inc_s), .clr(1'b0), .count(timeout_cnt)
    );

    sat_counter #(.W(CNT_W)) u_skip_cnt (
        .clk(clock40), .rst(reset), .inc(skip_inc_s), .clr(1'b0), .count(skip_cnt)
    );

endmodule

// File: tb/tb_halfstrip_checker.sv
// Self-checking bench for halfstrip_checker: directed table, hand-written
// reset/clear sequences and randomized trials against a trial-level model.
// A second instance with 2-bit counters shares the stimulus to exercise
// saturation.
module tb_halfstrip_checker;

    localparam int TO = 63;
    localparam int ST = 3;
    localparam int NSEQ = 80;

    logic        clock40 = 1'b0;
    logic        reset;
    logic        arm;
    logic [31:0] halfstrips;
    logic [31:0] halfstrips_expect;
    logic        compout;
    logic        compout_expect;
    logic        triad_skip;
    logic        halfstrips_errcnt_rst;
    logic        compout_errcnt_rst;

    logic        ready, done, timed_out;
    logic [31:0] halfstrips_captured;
    logic [7:0]  latency;
    logic [31:0] halfstrips_errcnt, compout_errcnt, trial_cnt, timeout_cnt, skip_cnt;

    logic        s_ready, s_done, s_timed_out;
    logic [31:0] s_captured;
    logic [7:0]  s_latency;
    logic [1:0]  s_herr, s_cerr, s_trial, s_to, s_skip;

    always #12 clock40 = ~clock40;

    halfstrip_checker #(.TIMEOUT(TO), .SETTLE(ST), .CNT_W(32)) dut (
        .clock40(clock40), .reset(reset), .arm(arm), .halfstrips(halfstrips),
        .halfstrips_expect(halfstrips_expect), .compout(compout),
        .compout_expect(compout_expect), .triad_skip(triad_skip),
        .halfstrips_errcnt_rst(halfstrips_errcnt_rst), .compout_errcnt_rst(compout_errcnt_rst),
        .ready(ready), .done(done), .halfstrips_captured(halfstrips_captured),
        .latency(latency), .timed_out(timed_out), .halfstrips_errcnt(halfstrips_errcnt),
        .compout_errcnt(compout_errcnt), .trial_cnt(trial_cnt), .timeout_cnt(timeout_cnt),
        .skip_cnt(skip_cnt)
    );

    halfstrip_checker #(.TIMEOUT(TO), .SETTLE(ST), .CNT_W(2)) dut_small (
        .clock40(clock40), .reset(reset), .arm(arm), .halfstrips(halfstrips),
        .halfstrips_expect(halfstrips_expect), .compout(compout),
        .compout_expect(compout_expect), .triad_skip(triad_skip),
        .halfstrips_errcnt_rst(halfstrips_errcnt_rst), .compout_errcnt_rst(compout_errcnt_rst),
        .ready(s_ready), .done(s_done), .halfstrips_captured(s_captured),
        .latency(s_latency), .timed_out(s_timed_out), .halfstrips_errcnt(s_herr),
        .compout_errcnt(s_cerr), .trial_cnt(s_trial), .timeout_cnt(s_to),
        .skip_cnt(s_skip)
    );

    int checks   = 0;
    int failures = 0;

    // Per-trial stimulus, index i is sampled at edge i+1 after the arm edge.
    logic [31:0] hs_seq  [0:NSEQ-1];
    logic        cmp_seq [0:NSEQ-1];
    logic        skp_seq [0:NSEQ-1];

    // Model results for the current trial.
    logic [31:0] md_cap;
    int          md_lat;
    bit          md_to, md_cseen, md_sseen;
    int          md_done_at;

    // Model counters.
    int unsigned m_trial, m_herr, m_cerr, m_to, m_skip;

    typedef struct {
        int          k;
        logic [31:0] hs_a;
        int          b_off;
        logic [31:0] hs_b;
        logic [31:0] exp_hs;
        int          cmp_pos;
        logic        cmp_exp;
        int          skip_pos;
        int          rearm;
        bit          clr_c;
        logic [31:0] e_cap;
        int          e_lat;
        bit          e_to;
        bit          e_herr;
        bit          e_cerr;
        bit          e_skip;
    } vec_t;

    vec_t tbl [0:13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat3(input int unsigned v);
        return (v > 3) ? 32'd3 : v;
    endfunction

    task automatic clear_seq();
        for (int i = 0; i < NSEQ; i++) begin
            hs_seq[i]  = 32'h0;
            cmp_seq[i] = 1'b0;
            skp_seq[i] = 1'b0;
        end
    endtask

    // Trial outcome from the rules: first nonzero sample within the window,
    // OR of that sample and the next ST samples, ORs of compout/skip over the
    // whole observed span.
    task automatic model_trial();
        int k;
        int last;
        k = -1;
        for (int i = 0; i <= TO; i++) begin
            if (k < 0 && hs_seq[i] != 32'h0) k = i;
        end
        md_cap = 32'h0;
        if (k >= 0) begin
            for (int i = k; i <= k + ST; i++) md_cap = md_cap | hs_seq[i];
            md_lat     = k;
            md_to      = 1'b0;
            last       = k + ST;
            md_done_at = 3 + ST + k;
        end else begin
            md_lat     = TO;
            md_to      = 1'b1;
            last       = TO;
            md_done_at = TO + 3;
        end
        md_cseen = 1'b0;
        md_sseen = 1'b0;
        for (int i = 0; i <= last; i++) begin
            md_cseen = md_cseen | cmp_seq[i];
            md_sseen = md_sseen | skp_seq[i];
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_trial_cnt"}, trial_cnt, m_trial);
        chk({tag, "_hs_errcnt"}, halfstrips_errcnt, m_herr);
        chk({tag, "_cmp_errcnt"}, compout_errcnt, m_cerr);
        chk({tag, "_timeout_cnt"}, timeout_cnt, m_to);
        chk({tag, "_skip_cnt"}, skip_cnt, m_skip);
        chk({tag, "_sat_trial"}, {30'd0, s_trial}, sat3(m_trial));
        chk({tag, "_sat_herr"}, {30'd0, s_herr}, sat3(m_herr));
        chk({tag, "_sat_cerr"}, {30'd0, s_cerr}, sat3(m_cerr));
        chk({tag, "_sat_to"}, {30'd0, s_to}, sat3(m_to));
        chk({tag, "_sat_skip"}, {30'd0, s_skip}, sat3(m_skip));
    endtask

    task automatic apply_counts(input bit herr, input bit cerr, input bit to, input bit sk,
                                input bit clr_c, input string tag);
        m_trial++;
        m_herr = m_herr + herr;
        if (clr_c) m_cerr = 0;
        else       m_cerr = m_cerr + cerr;
        m_to   = m_to + to;
        m_skip = m_skip + sk;
        check_counters(tag);
    endtask

    // Arm a trial from the current sequences, run it to done and check timing.
    task automatic run_trial(input logic [31:0] exp_hs, input logic exp_cmp,
                             input int rearm_pos, input bit clr_c);
        int got_at;
        model_trial();
        halfstrips_expect = exp_hs;
        compout_expect    = exp_cmp;
        arm               = 1'b1;
        @(posedge clock40); #1;
        arm = 1'b0;
        chk("ready_drop", {31'd0, ready}, 32'd0);
        got_at = -1;
        for (int e = 0; e < 150; e++) begin
            if (done === 1'b1) begin
                got_at = e + 1;
                break;
            end
            if (e < NSEQ) begin
                halfstrips = hs_seq[e];
                compout    = cmp_seq[e];
                triad_skip = skp_seq[e];
            end else begin
                halfstrips = 32'h0;
                compout    = 1'b0;
                triad_skip = 1'b0;
            end
            arm                = (e == rearm_pos);
            compout_errcnt_rst = clr_c && ((e + 1) == (md_done_at - 1));
            @(posedge clock40); #1;
        end
        halfstrips         = 32'h0;
        compout            = 1'b0;
        triad_skip         = 1'b0;
        arm                = 1'b0;
        compout_errcnt_rst = 1'b0;
        chk("done_at", got_at, md_done_at);
        chk("ready_on_done", {31'd0, ready}, 32'd1);
    endtask

    task automatic after_done();
        @(posedge clock40); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; halfstrips = 32'h0; halfstrips_expect = 32'h0;
        compout = 1'b0; compout_expect = 1'b0; triad_skip = 1'b0;
        halfstrips_errcnt_rst = 1'b0; compout_errcnt_rst = 1'b0;
        m_trial = 0; m_herr = 0; m_cerr = 0; m_to = 0; m_skip = 0;

        //                k   hs_a          boff hs_b        exp_hs      cpos cexp spos rearm clr  e_cap        lat to herr cerr skip
        tbl[0]  = '{ 2, 32'h0000_0010, -1, 32'h0,      32'h0000_0010, -1, 1'b0, -1, -1, 1'b0, 32'h0000_0010,  2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{ 0, 32'h0000_0001,  1, 32'h100,    32'h0000_0101, -1, 1'b0, -1, -1, 1'b0, 32'h0000_0101,  0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{ 0, 32'h0000_0001,  1, 32'h100,    32'h0000_0001, -1, 1'b0, -1, -1, 1'b0, 32'h0000_0101,  0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{-1, 32'h0,         -1, 32'h0,      32'h0000_0004, -1, 1'b0, -1, -1, 1'b0, 32'h0,         63, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{-1, 32'h0,         -1, 32'h0,      32'h0,         -1, 1'b0, -1, -1, 1'b0, 32'h0,         63, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{ 0, 32'h0000_0008, -1, 32'h0,      32'h0000_0008, -1, 1'b1, -1, -1, 1'b0, 32'h0000_0008,  0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{ 0, 32'h0000_0008, -1, 32'h0,      32'h0000_0009, -1, 1'b1, -1, -1, 1'b1, 32'h0000_0008,  0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{ 1, 32'h0000_0002, -1, 32'h0,      32'h0000_0002,  3, 1'b1, -1, -1, 1'b0, 32'h0000_0002,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{ 5, 32'h0000_0040, -1, 32'h0,      32'h0000_0040, -1, 1'b0,  2, -1, 1'b0, 32'h0000_0040,  5, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{63, 32'h8000_0000, -1, 32'h0,      32'h8000_0000, -1, 1'b0, -1, -1, 1'b0, 32'h8000_0000, 63, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{ 0, 32'h0000_0001,  4, 32'h2,      32'h0000_0001, -1, 1'b0, -1, -1, 1'b0, 32'h0000_0001,  0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{10, 32'h0000_00F0, -1, 32'h0,      32'h0000_00F0, -1, 1'b0, -1,  3, 1'b0, 32'h0000_00F0, 10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{ 0, 32'h0000_0003,  3, 32'h4,      32'h0000_0007, -1, 1'b0, -1, -1, 1'b0, 32'h0000_0007,  0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{64, 32'h0000_0005, -1, 32'h0,      32'h0,         -1, 1'b0, -1, -1, 1'b0, 32'h0,         63, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clock40);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_captured", halfstrips_captured, 32'h0);
        chk("rst_latency", {24'd0, latency}, 32'd0);
        chk("rst_timed_out", {31'd0, timed_out}, 32'd0);
        check_counters("rst");
        reset = 1'b0;
        @(posedge clock40); #1;

        // Reset during SETTLE aborts the trial silently.
        halfstrips_expect = 32'h1;
        arm = 1'b1;
        @(posedge clock40); #1;
        arm = 1'b0; halfstrips = 32'h1;
        @(posedge clock40); #1;
        halfstrips = 32'h0;
        @(posedge clock40); #1;
        reset = 1'b1;
        @(posedge clock40); #1;
        reset = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        begin
            int dcount;
            dcount = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clock40); #1;
                if (done === 1'b1) dcount++;
            end
            chk("abort_no_done", dcount, 32'd0);
        end
        check_counters("abort");

        // Directed table.
        for (int t = 0; t < 14; t++) begin
            clear_seq();
            if (tbl[t].k >= 0) hs_seq[tbl[t].k] = tbl[t].hs_a;
            if (tbl[t].b_off >= 0) hs_seq[tbl[t].k + tbl[t].b_off] = tbl[t].hs_b;
            if (tbl[t].cmp_pos >= 0) cmp_seq[tbl[t].cmp_pos] = 1'b1;
            if (tbl[t].skip_pos >= 0) skp_seq[tbl[t].skip_pos] = 1'b1;
            run_trial(tbl[t].exp_hs, tbl[t].cmp_exp, tbl[t].rearm, tbl[t].clr_c);
            chk($sformatf("tbl%0d_captured", t), halfstrips_captured, tbl[t].e_cap);
            chk($sformatf("tbl%0d_latency", t), {24'd0, latency}, tbl[t].e_lat);
            chk($sformatf("tbl%0d_timed_out", t), {31'd0, timed_out}, {31'd0, tbl[t].e_to});
            apply_counts(tbl[t].e_herr, tbl[t].e_cerr, tbl[t].e_to, tbl[t].e_skip,
                         tbl[t].clr_c, $sformatf("tbl%0d", t));
            after_done();
        end

        // Standalone clear of the half-strip error counter.
        halfstrips_errcnt_rst = 1'b1;
        @(posedge clock40); #1;
        halfstrips_errcnt_rst = 1'b0;
        m_herr = 0;
        check_counters("hs_clr");

        // Randomized trials.
        for (int r = 0; r < 30; r++) begin
            int          k;
            int          sel;
            int          rearm;
            bit          clr_c;
            logic [31:0] exp_hs;
            logic        exp_cmp;
            clear_seq();
            k = $urandom_range(0, 70);
            for (int i = 0; i < NSEQ; i++) begin
                if (i == k) hs_seq[i] = $urandom | (32'h1 << $urandom_range(0, 31));
                else if (i > k && $urandom_range(0, 2) == 0) hs_seq[i] = 32'h1 << $urandom_range(0, 31);
                cmp_seq[i] = ($urandom_range(0, 19) == 0);
                skp_seq[i] = ($urandom_range(0, 39) == 0);
            end
            model_trial();
            sel = $urandom_range(0, 2);
            if (sel == 0)      exp_hs = md_cap;
            else if (sel == 1) exp_hs = $urandom;
            else               exp_hs = 32'h0;
            exp_cmp = $urandom_range(0, 1);
            clr_c   = ($urandom_range(0, 7) == 0);
            rearm   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, md_done_at - 3) : -1;
            run_trial(exp_hs, exp_cmp, rearm, clr_c);
            chk($sformatf("rnd%0d_captured", r), halfstrips_captured, md_cap);
            chk($sformatf("rnd%0d_latency", r), {24'd0, latency}, md_lat);
            chk($sformatf("rnd%0d_timed_out", r), {31'd0, timed_out}, {31'd0, md_to});
            apply_counts(md_cap != exp_hs, md_cseen != exp_cmp, md_to, md_sseen, clr_c,
                         $sformatf("rnd%0d", r));
            after_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
